regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_pkg.sv | 17 +
 rtl/regfile_write_arbiter_rr_arbiter.sv | 44 ++++
 rtl/regfile_write_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// the hard-wired zero register and the commit-stage record.
package regfile_write_arbiter_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    // Register 0 is hard-wired; writes to it are accepted but never committed.
    localparam logic [ADDR_W_DEF-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } commit_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin selector: scans requesters upward from i_ptr (wrapping) and
// grants the first valid one; nothing is granted while i_hold is high.
module rr_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    input  logic               i_hold,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any
);

    logic [IDX_W:0]   w_pos;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_pos       = '0;
        w_idx       = '0;
        w_found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // One extra bit on w_pos lets ptr+k exceed NUM_REQ before the wrap.
            w_pos = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_pos >= (IDX_W+1)'(NUM_REQ)) begin
                w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
            end
            w_idx = w_pos[IDX_W-1:0];
            if (!w_found && !i_hold && i_valid[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin writeback arbiter feeding a one-cycle register-file commit stage,
// with read-port hazard flags. REGFILE_WRITE_ARB_BYPASS_EN adds forwarding outputs.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           hold,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [ADDR_W-1:0]              rd_addr1,
    input  logic [ADDR_W-1:0]              rd_addr2,
    output logic                           rf_we,
    output logic [ADDR_W-1:0]              rf_waddr,
    output logic [DATA_W-1:0]              rf_wdata,
    output logic                           hazard1,
    output logic                           hazard2,
`ifdef REGFILE_WRITE_ARB_BYPASS_EN
    output logic                           fwd_valid1,
    output logic [DATA_W-1:0]              fwd_data1,
    output logic                           fwd_valid2,
    output logic [DATA_W-1:0]              fwd_data2,
`endif
    output logic                           busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a requester holds valid with stable addr/data until it sees
    // ready; the transfer happens at the rising edge where valid&ready is high.
    logic [IDX_W-1:0]   r_ptr;
    commit_t            r_stage;
    logic               r_busy;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_any;
    logic               w_hold_eff;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;

    // Reset also suppresses grants so ready stays low while rst is asserted.
    assign w_hold_eff = hold | rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_valid     (req_valid),
        .i_ptr       (r_ptr),
        .i_hold      (w_hold_eff),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    assign req_ready  = w_grant;
    assign w_sel_addr = req_addr[w_grant_idx];
    assign w_sel_data = req_data[w_grant_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_stage <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= w_any;
            if (w_any) begin
                r_ptr         <= (w_grant_idx == IDX_W'(NUM_REQ-1)) ? '0
                                 : w_grant_idx + IDX_W'(1);
                r_stage.we    <= (w_sel_addr != ADDR_W'(ZERO_REG));
                r_stage.addr  <= ADDR_W_DEF'(w_sel_addr);
                r_stage.data  <= DATA_W_DEF'(w_sel_data);
            end else begin
                r_stage <= '0;
            end
        end
    end

    assign rf_we    = r_stage.we;
    assign rf_waddr = ADDR_W'(r_stage.addr);
    assign rf_wdata = DATA_W'(r_stage.data);
    assign busy     = r_busy;

    assign hazard1 = rf_we && (rf_waddr == rd_addr1) && (rd_addr1 != ADDR_W'(ZERO_REG));
    assign hazard2 = rf_we && (rf_waddr == rd_addr2) && (rd_addr2 != ADDR_W'(ZERO_REG));

`ifdef REGFILE_WRITE_ARB_BYPASS_EN
    assign fwd_valid1 = hazard1;
    assign fwd_data1  = hazard1 ? rf_wdata : '0;
    assign fwd_valid2 = hazard2;
    assign fwd_data2  = hazard2 ? rf_wdata : '0;
`endif

endmodule
